pong_collision_scorer: RTL and testbench

Sequential, parametrised successor to the combinational collision checker in the pong datapath. Samples ball and paddle coordinates on each ball-update strobe and produces registered one-cycle wall/paddle event pulses. Owns the two score counters, a rally-hit counter and a PLAY / POINT / GAME_OVER state machine. Sits between the ball-motion block, which consumes the collision pulses to reflect velocity, and the display/score logic.

---
 rtl/pong_collision_scorer_if.sv | 37 +++
 rtl/pong_collision_scorer.sv | 169 ++++++++++++++++
 tb/tb_pong_collision_scorer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pong_collision_scorer_if.sv
// Bus bundle between the ball-motion/display side and the collision scorer.
// The scorer's sample and control inputs, plus its event pulses and score state.
interface pong_collision_scorer_if #(
    parameter int unsigned COORD_W = 6,
    parameter int unsigned SCORE_W = 3,
    parameter int unsigned RALLY_W = 8
);
    logic               new_game;
    logic               serve;
    logic               ball_valid;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [COORD_W-1:0] p1y;
    logic [COORD_W-1:0] p2y;

    logic [1:0]         paddle_collision;
    logic               wall_collision;
    logic               point_p1;
    logic               point_p2;
    logic [SCORE_W-1:0] sc1;
    logic [SCORE_W-1:0] sc2;
    logic [RALLY_W-1:0] rally;
    logic [1:0]         state;
    logic [1:0]         winner;

    modport master (
        output new_game, serve, ball_valid, bx, by, p1y, p2y,
        input  paddle_collision, wall_collision, point_p1, point_p2,
        input  sc1, sc2, rally, state, winner
    );

    modport slave (
        input  new_game, serve, ball_valid, bx, by, p1y, p2y,
        output paddle_collision, wall_collision, point_p1, point_p2,
        output sc1, sc2, rally, state, winner
    );
endinterface

// File: rtl/pong_collision_scorer.sv
// Registered pong collision detector with score/rally counters and a
// PLAY / POINT / GAME_OVER match state machine.
module pong_collision_scorer #(
    parameter int unsigned COORD_W   = 6,
    parameter int unsigned FIELD_W   = 64,
    parameter int unsigned FIELD_H   = 64,
    parameter int unsigned PADDLE_H  = 4,
    parameter int unsigned L_HIT_X   = 2,
    parameter int unsigned R_HIT_X   = FIELD_W - 3,
    parameter int unsigned SCORE_W   = 3,
    parameter int unsigned WIN_SCORE = 7,
    parameter int unsigned RALLY_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    pong_collision_scorer_if.slave  bus
);
    localparam int unsigned EXT_W = COORD_W + 1;
    localparam logic [RALLY_W-1:0] RALLY_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'b00,
        ST_POINT     = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] sc1_q, sc1_d;
    logic [SCORE_W-1:0] sc2_q, sc2_d;
    logic [RALLY_W-1:0] rally_q, rally_d;
    logic [1:0]         winner_q, winner_d;
    logic [1:0]         hist_q, hist_d;
    logic [1:0]         paddle_q, paddle_d;
    logic               wall_q, wall_d;
    logic               pt1_q, pt1_d;
    logic               pt2_q, pt2_d;

    logic [1:0]         hit_raw_c;
    logic               wall_raw_c;
    logic               miss_left_c;
    logic               miss_right_c;

    // Paddle span is summed one bit wider so a paddle near the bottom never wraps.
    function automatic logic paddle_hit(input logic [COORD_W-1:0] y,
                                        input logic [COORD_W-1:0] top);
        logic [EXT_W-1:0] bot;
        bot = {1'b0, top} + EXT_W'(PADDLE_H - 1);
        if (bot > EXT_W'(FIELD_H - 1)) begin
            bot = EXT_W'(FIELD_H - 1);
        end
        return (y >= top) && ({1'b0, y} <= bot);
    endfunction

    // Raw geometric tests on the current sample.
    always_comb begin
        hit_raw_c[0] = (bus.bx == COORD_W'(L_HIT_X)) && paddle_hit(bus.by, bus.p1y);
        hit_raw_c[1] = (bus.bx == COORD_W'(R_HIT_X)) && paddle_hit(bus.by, bus.p2y);
        wall_raw_c   = (bus.by == '0) || (bus.by == COORD_W'(FIELD_H - 1));
        miss_left_c  = (bus.bx == '0);
        miss_right_c = (bus.bx == COORD_W'(FIELD_W - 1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        sc1_d    = sc1_q;
        sc2_d    = sc2_q;
        rally_d  = rally_q;
        winner_d = winner_q;
        hist_d   = hist_q;
        paddle_d = 2'b00;
        wall_d   = 1'b0;
        pt1_d    = 1'b0;
        pt2_d    = 1'b0;

        if (bus.new_game) begin
            state_d  = ST_PLAY;
            sc1_d    = '0;
            sc2_d    = '0;
            rally_d  = '0;
            winner_d = WIN_NONE;
            hist_d   = 2'b00;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (bus.ball_valid) begin
                        // History is the raw hit, so a dwelling ball counts once.
                        hist_d   = hit_raw_c;
                        paddle_d = hit_raw_c & ~hist_q;
                        wall_d   = wall_raw_c;
                        if ((paddle_d != 2'b00) && (rally_q != RALLY_MAX)) begin
                            rally_d = rally_q + RALLY_W'(1);
                        end
                        if (miss_left_c) begin
                            pt2_d   = 1'b1;
                            rally_d = '0;
                            sc2_d   = sc2_q + SCORE_W'(1);
                            if (sc2_d == WIN_VAL) begin
                                state_d  = ST_GAME_OVER;
                                winner_d = WIN_P2;
                            end else begin
                                state_d = ST_POINT;
                            end
                        end else if (miss_right_c) begin
                            pt1_d   = 1'b1;
                            rally_d = '0;
                            sc1_d   = sc1_q + SCORE_W'(1);
                            if (sc1_d == WIN_VAL) begin
                                state_d  = ST_GAME_OVER;
                                winner_d = WIN_P1;
                            end else begin
                                state_d = ST_POINT;
                            end
                        end
                    end
                end
                ST_POINT: begin
                    if (bus.serve) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_PLAY;
            sc1_q    <= '0;
            sc2_q    <= '0;
            rally_q  <= '0;
            winner_q <= WIN_NONE;
            hist_q   <= 2'b00;
            paddle_q <= 2'b00;
            wall_q   <= 1'b0;
            pt1_q    <= 1'b0;
            pt2_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sc1_q    <= sc1_d;
            sc2_q    <= sc2_d;
            rally_q  <= rally_d;
            winner_q <= winner_d;
            hist_q   <= hist_d;
            paddle_q <= paddle_d;
            wall_q   <= wall_d;
            pt1_q    <= pt1_d;
            pt2_q    <= pt2_d;
        end
    end

    assign bus.paddle_collision = paddle_q;
    assign bus.wall_collision   = wall_q;
    assign bus.point_p1         = pt1_q;
    assign bus.point_p2         = pt2_q;
    assign bus.sc1              = sc1_q;
    assign bus.sc2              = sc2_q;
    assign bus.rally            = rally_q;
    assign bus.state            = state_q;
    assign bus.winner           = winner_q;

endmodule

// File: tb/tb_pong_collision_scorer.sv
// Scoreboard bench for pong_collision_scorer: directed samples queue their
// hand-computed post-edge outputs; a monitor compares after each tagged edge.
module tb_pong_collision_scorer;
    localparam logic [1:0] PL = 2'b00;
    localparam logic [1:0] PT = 2'b01;
    localparam logic [1:0] GO = 2'b10;

    typedef struct packed {
        logic [1:0] paddle;
        logic       wall;
        logic       pt1;
        logic       pt2;
        logic [2:0] sc1;
        logic [2:0] sc2;
        logic [7:0] rally;
        logic [1:0] state;
        logic [1:0] winner;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic tag = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t  exp_q[$];
    string name_q[$];

    pong_collision_scorer_if #(.COORD_W(6), .SCORE_W(3), .RALLY_W(8)) bus ();

    pong_collision_scorer #(
        .COORD_W(6), .FIELD_W(64), .FIELD_H(64), .PADDLE_H(4), .L_HIT_X(2),
        .R_HIT_X(61), .SCORE_W(3), .WIN_SCORE(7), .RALLY_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] paddle, input logic wall,
                                input logic pt1, input logic pt2,
                                input logic [2:0] sc1, input logic [2:0] sc2,
                                input logic [7:0] rally, input logic [1:0] state,
                                input logic [1:0] winner);
        exp_t e;
        e.paddle = paddle; e.wall = wall; e.pt1 = pt1; e.pt2 = pt2;
        e.sc1 = sc1; e.sc2 = sc2; e.rally = rally; e.state = state; e.winner = winner;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic op(input string name, input logic rst, input logic ng,
                      input logic sv, input logic bv, input logic [5:0] x,
                      input logic [5:0] y, input logic [5:0] a, input logic [5:0] b,
                      input exp_t e);
        @(negedge clk);
        reset          = rst;
        bus.new_game   = ng;
        bus.serve      = sv;
        bus.ball_valid = bv;
        bus.bx = x; bus.by = y; bus.p1y = a; bus.p2y = b;
        tag = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: compare every output after each tagged edge.
    always @(posedge clk) begin
        if (tag) begin
            exp_t  act;
            exp_t  e;
            string n;
            #1;
            act.paddle = bus.paddle_collision;
            act.wall   = bus.wall_collision;
            act.pt1    = bus.point_p1;
            act.pt2    = bus.point_p2;
            act.sc1    = bus.sc1;
            act.sc2    = bus.sc2;
            act.rally  = bus.rally;
            act.state  = bus.state;
            act.winner = bus.winner;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, no expectation queued", act);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.new_game = 1'b0; bus.serve = 1'b0; bus.ball_valid = 1'b0;
        bus.bx = '0; bus.by = '0; bus.p1y = '0; bus.p2y = '0;

        op("reset", 1, 0, 0, 0, 6'd30, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,0,0,0,PL,0));

        // Walls
        op("wall_top",    0, 0, 0, 1, 6'd30, 6'd0,  6'd10, 6'd10, mk(0,1,0,0,0,0,0,PL,0));
        op("wall_bottom", 0, 0, 0, 1, 6'd30, 6'd63, 6'd10, 6'd10, mk(0,1,0,0,0,0,0,PL,0));
        op("idle_no_pulse", 0, 0, 0, 0, 6'd30, 6'd63, 6'd10, 6'd10, mk(0,0,0,0,0,0,0,PL,0));

        // Left hit, dwell dedup, right hit
        op("left_hit",   0, 0, 0, 1, 6'd2,  6'd21, 6'd19, 6'd10, mk(2'b01,0,0,0,0,0,1,PL,0));
        op("left_dwell", 0, 0, 0, 1, 6'd2,  6'd21, 6'd19, 6'd10, mk(2'b00,0,0,0,0,0,1,PL,0));
        op("right_hit",  0, 0, 0, 1, 6'd61, 6'd20, 6'd19, 6'd18, mk(2'b10,0,0,0,0,0,2,PL,0));

        // Paddle edges
        op("edge_hit_wall",  0, 0, 0, 1, 6'd2, 6'd63, 6'd60, 6'd10, mk(2'b01,1,0,0,0,0,3,PL,0));
        op("edge_above",     0, 0, 0, 1, 6'd2, 6'd59, 6'd60, 6'd10, mk(2'b00,0,0,0,0,0,3,PL,0));
        op("edge_nowrap",    0, 0, 0, 1, 6'd2, 6'd63, 6'd62, 6'd10, mk(2'b01,1,0,0,0,0,4,PL,0));

        // Miss and serve
        op("miss_p2",       0, 0, 0, 1, 6'd0, 6'd30, 6'd10, 6'd10, mk(0,0,0,1,0,1,0,PT,0));
        op("point_ignored", 0, 0, 0, 1, 6'd0, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,0,1,0,PT,0));
        op("serve",         0, 0, 1, 0, 6'd0, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,0,1,0,PL,0));
        op("wall_and_miss", 0, 0, 0, 1, 6'd0, 6'd0,  6'd10, 6'd10, mk(0,1,0,1,0,2,0,PT,0));
        op("serve2",        0, 0, 1, 0, 6'd30, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,0,2,0,PL,0));
        op("serve_in_play", 0, 0, 1, 0, 6'd30, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,0,2,0,PL,0));

        // Player 1 wins
        for (int k = 1; k <= 7; k++) begin
            op("miss_p1", 0, 0, 0, 1, 6'd63, 6'd30, 6'd10, 6'd10,
               mk(0,0,1,0,3'(k),2,0,(k == 7) ? GO : PT,(k == 7) ? 2'b01 : 2'b00));
            if (k < 7) begin
                op("serve_loop", 0, 0, 1, 0, 6'd30, 6'd30, 6'd10, 6'd10,
                   mk(0,0,0,0,3'(k),2,0,PL,0));
            end
        end
        op("over_miss_ign", 0, 0, 0, 1, 6'd63, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,7,2,0,GO,2'b01));
        op("over_hit_ign",  0, 0, 0, 1, 6'd2,  6'd21, 6'd19, 6'd10, mk(0,0,0,0,7,2,0,GO,2'b01));
        op("over_serve",    0, 0, 1, 0, 6'd30, 6'd30, 6'd10, 6'd10, mk(0,0,0,0,7,2,0,GO,2'b01));
        op("new_game_prio", 0, 1, 1, 1, 6'd0,  6'd0,  6'd10, 6'd10, mk(0,0,0,0,0,0,0,PL,0));

        // new_game clears dedup history
        op("hit_before_ng", 0, 0, 0, 1, 6'd2, 6'd21, 6'd19, 6'd10, mk(2'b01,0,0,0,0,0,1,PL,0));
        op("new_game",      0, 1, 0, 0, 6'd2, 6'd21, 6'd19, 6'd10, mk(0,0,0,0,0,0,0,PL,0));
        op("hit_after_ng",  0, 0, 0, 1, 6'd2, 6'd21, 6'd19, 6'd10, mk(2'b01,0,0,0,0,0,1,PL,0));

        // Reset in POINT with sc1=3
        for (int k = 1; k <= 3; k++) begin
            op("miss_p1_pre_rst", 0, 0, 0, 1, 6'd63, 6'd30, 6'd10, 6'd10,
               mk(0,0,1,0,3'(k),0,0,PT,0));
            if (k < 3) begin
                op("serve_pre_rst", 0, 0, 1, 0, 6'd30, 6'd30, 6'd10, 6'd10,
                   mk(0,0,0,0,3'(k),0,0,PL,0));
            end
        end
        op("reset_in_point", 1, 1, 1, 1, 6'd63, 6'd0, 6'd10, 6'd10, mk(0,0,0,0,0,0,0,PL,0));
        op("wall_after_rst", 0, 0, 0, 1, 6'd30, 6'd0, 6'd10, 6'd10, mk(0,1,0,0,0,0,0,PL,0));

        // Rally saturation with alternating paddle hits
        for (int i = 1; i <= 260; i++) begin
            op("rally_sat", 0, 0, 0, 1, (i % 2 == 1) ? 6'd2 : 6'd61, 6'd20, 6'd18, 6'd18,
               mk((i % 2 == 1) ? 2'b01 : 2'b10, 0, 0, 0, 0, 0,
                  (i > 255) ? 8'd255 : 8'(i), PL, 0));
        end

        @(negedge clk);
        tag = 1'b0;
        bus.ball_valid = 1'b0; bus.serve = 1'b0; bus.new_game = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
